rf_resp_sim: RTL and testbench

RF_RESP_SIM -- requirements
Module: rf_resp_sim

---
 rtl/rf_resp_sim.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_rf_resp_sim.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_resp_sim.sv
// rf_resp_sim: UART/RS485 responder that emulates the configuration port of an
// RF module. Framed commands on i_rx either set (CMD 0x01) or query (CMD 0x02)
// the frequency word and the up/down-link gains. Each good frame is answered on
// o_tx after a bus-turnaround gap, with the RS485 driver enable o_tx_ctrl
// framing the answer.
//
// Ports:
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   i_rx         UART command line (asynchronous, idle high)
//   o_tx         UART answer line (idle high)
//   o_tx_ctrl    RS485 driver enable, high while answering
//   o_rf_freq    last accepted frequency word
//   o_up_gain    last accepted up-link gain
//   o_down_gain  last accepted down-link gain
//   o_cfg_vld    one-cycle pulse when a set command updates the config
//   o_frm_cnt    count of good frames (wraps)
//   o_err_cnt    count of bad frames, bad bytes and timeouts (wraps)
module rf_resp_sim #(
  parameter int CLK_FREQ = 200000000,
  parameter int BAUD     = 115200,
  parameter int TURN_CYC = 2000,
  parameter int IDLE_TO  = 4 * 10 * (CLK_FREQ / BAUD)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_rx,
  output logic        o_tx,
  output logic        o_tx_ctrl,
  output logic [15:0] o_rf_freq,
  output logic [7:0]  o_up_gain,
  output logic [7:0]  o_down_gain,
  output logic        o_cfg_vld,
  output logic [31:0] o_frm_cnt,
  output logic [31:0] o_err_cnt
);

  localparam int BIT_CYC  = CLK_FREQ / BAUD;
  localparam int HALF_CYC = BIT_CYC / 2;

  typedef enum logic [2:0] {RX_ARM, RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {HDR0, HDR1, BODY, CHK} ps_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_TURN, TX_DE_ON, TX_SEND, TX_DE_OFF} tx_state_t;

  rx_state_t   rx_state, rx_nxt;
  ps_state_t   ps_state, ps_nxt;
  tx_state_t   tx_state, tx_nxt;

  logic        rx_meta, rx_sync, rx_prev;
  logic [31:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_half, rx_full, byte_done, frame_err;

  logic [7:0]  body [0:4];
  logic [2:0]  body_idx;
  logic [31:0] idle_cnt;
  logic [7:0]  chk_calc, ans_cmd, ans_chk, tx_cur;
  logic        tx_start, tx_busy, rx_ok, rx_bad;
  logic        good_set, good_ask, err_inc;

  logic [31:0] tx_cnt;
  logic [3:0]  tx_bit;
  logic [2:0]  tx_idx;
  logic        tx_full;

  // Two-flop synchroniser; rx_prev gives the falling-edge detector its history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_half = (rx_cnt == 32'(HALF_CYC - 1));
  assign rx_full = (rx_cnt == 32'(BIT_CYC - 1));

  // RX_ARM waits for one full bit time of idle-high line after reset so that
  // a line still mid-byte at release is not mistaken for a start bit.
  always_comb begin
    rx_nxt    = rx_state;
    byte_done = 1'b0;
    frame_err = 1'b0;
    case (rx_state)
      RX_ARM:   if (rx_sync && rx_full) rx_nxt = RX_IDLE;
      RX_IDLE:  if (rx_prev && !rx_sync) rx_nxt = RX_START;
      RX_START: if (rx_half) rx_nxt = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_full && rx_bit == 3'd7) rx_nxt = RX_STOP;
      RX_STOP: begin
        if (rx_full) begin
          rx_nxt    = RX_IDLE;
          byte_done = rx_sync;
          frame_err = !rx_sync;
        end
      end
      default:  rx_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_ARM;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_nxt;
      if (rx_nxt != rx_state || rx_state == RX_IDLE ||
          (rx_state == RX_DATA && rx_full) || (rx_state == RX_ARM && !rx_sync))
        rx_cnt <= '0;
      else
        rx_cnt <= rx_cnt + 32'd1;
      if (rx_state == RX_START)
        rx_bit <= '0;
      else if (rx_state == RX_DATA && rx_full) begin
        rx_shift <= {rx_sync, rx_shift[7:1]};
        rx_bit   <= rx_bit + 3'd1;
      end
    end
  end

  // tx_start is included so a byte landing between the verdict and TX_TURN is
  // also dropped.
  assign tx_busy  = (tx_state != TX_IDLE) || tx_start;
  assign rx_ok    = byte_done && !tx_busy;
  assign rx_bad   = frame_err && !tx_busy;
  assign chk_calc = body[0] ^ body[1] ^ body[2] ^ body[3] ^ body[4];

  // Parser: a completed byte wins over a timeout expiring in the same cycle,
  // and every error source funnels into a single err_inc so the counter moves
  // by at most one per cycle.
  always_comb begin
    ps_nxt   = ps_state;
    good_set = 1'b0;
    good_ask = 1'b0;
    err_inc  = 1'b0;
    if (tx_busy) begin
      ps_nxt = HDR0;
    end else if (rx_bad) begin
      ps_nxt  = HDR0;
      err_inc = 1'b1;
    end else if (rx_ok) begin
      case (ps_state)
        HDR0: if (rx_shift == 8'hAA) ps_nxt = HDR1;
        HDR1: begin
          if (rx_shift == 8'h55)      ps_nxt = BODY;
          else if (rx_shift != 8'hAA) ps_nxt = HDR0;
        end
        BODY: if (body_idx == 3'd4) ps_nxt = CHK;
        CHK: begin
          ps_nxt = HDR0;
          if (rx_shift == chk_calc && body[0] == 8'h01)      good_set = 1'b1;
          else if (rx_shift == chk_calc && body[0] == 8'h02) good_ask = 1'b1;
          else                                               err_inc  = 1'b1;
        end
        default: ps_nxt = HDR0;
      endcase
    end else if (ps_state != HDR0 && idle_cnt >= 32'(IDLE_TO)) begin
      ps_nxt  = HDR0;
      err_inc = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_state    <= HDR0;
      body_idx    <= '0;
      idle_cnt    <= '0;
      for (int i = 0; i < 5; i++) body[i] <= '0;
      o_rf_freq   <= '0;
      o_up_gain   <= '0;
      o_down_gain <= '0;
      o_cfg_vld   <= 1'b0;
      o_frm_cnt   <= '0;
      o_err_cnt   <= '0;
      tx_start    <= 1'b0;
      ans_cmd     <= '0;
    end else begin
      ps_state  <= ps_nxt;
      o_cfg_vld <= good_set;
      tx_start  <= good_set | good_ask;
      if (ps_state == HDR0 || rx_ok)
        idle_cnt <= '0;
      else
        idle_cnt <= idle_cnt + 32'd1;
      if (ps_state == HDR1)
        body_idx <= '0;
      else if (ps_state == BODY && rx_ok) begin
        body[body_idx] <= rx_shift;
        body_idx       <= body_idx + 3'd1;
      end
      if (good_set || good_ask) begin
        ans_cmd   <= body[0] | 8'h80;
        o_frm_cnt <= o_frm_cnt + 32'd1;
      end
      if (good_set) begin
        o_rf_freq   <= {body[1], body[2]};
        o_up_gain   <= body[3];
        o_down_gain <= body[4];
      end
      if (err_inc)
        o_err_cnt <= o_err_cnt + 32'd1;
    end
  end

  // The answer is built from the live config registers; they cannot change
  // while TX is busy because the parser is held in HDR0.
  assign ans_chk = ans_cmd ^ o_rf_freq[15:8] ^ o_rf_freq[7:0] ^ o_up_gain ^ o_down_gain;
  assign tx_full = (tx_cnt == 32'(BIT_CYC - 1));

  always_comb begin
    case (tx_idx)
      3'd0:    tx_cur = 8'h55;
      3'd1:    tx_cur = 8'hAA;
      3'd2:    tx_cur = ans_cmd;
      3'd3:    tx_cur = o_rf_freq[15:8];
      3'd4:    tx_cur = o_rf_freq[7:0];
      3'd5:    tx_cur = o_up_gain;
      3'd6:    tx_cur = o_down_gain;
      default: tx_cur = ans_chk;
    endcase
  end

  // Line outputs decode straight from the state register so that reset drops
  // the driver enable in the same cycle rather than one edge later.
  always_comb begin
    tx_nxt    = tx_state;
    o_tx      = 1'b1;
    o_tx_ctrl = 1'b0;
    case (tx_state)
      TX_IDLE: if (tx_start) tx_nxt = TX_TURN;
      TX_TURN: if (tx_cnt == 32'(TURN_CYC - 1)) tx_nxt = TX_DE_ON;
      TX_DE_ON: begin
        o_tx_ctrl = 1'b1;
        if (tx_full) tx_nxt = TX_SEND;
      end
      TX_SEND: begin
        o_tx_ctrl = 1'b1;
        if (tx_bit == 4'd0)      o_tx = 1'b0;
        else if (tx_bit == 4'd9) o_tx = 1'b1;
        else                     o_tx = tx_cur[3'(tx_bit - 4'd1)];
        if (tx_full && tx_bit == 4'd9 && tx_idx == 3'd7) tx_nxt = TX_DE_OFF;
      end
      TX_DE_OFF: begin
        o_tx_ctrl = 1'b1;
        if (tx_full) tx_nxt = TX_IDLE;
      end
      default: tx_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_idx   <= '0;
    end else begin
      tx_state <= tx_nxt;
      if (tx_nxt != tx_state || (tx_state == TX_SEND && tx_full))
        tx_cnt <= '0;
      else
        tx_cnt <= tx_cnt + 32'd1;
      if (tx_state != TX_SEND) begin
        tx_bit <= '0;
        tx_idx <= '0;
      end else if (tx_full) begin
        if (tx_bit == 4'd9) begin
          tx_bit <= '0;
          tx_idx <= tx_idx + 3'd1;
        end else begin
          tx_bit <= tx_bit + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rf_resp_sim.sv
// Self-checking bench for rf_resp_sim. Stimulus tasks push expected answer
// bytes and config updates into queues; independent monitor processes decode
// o_tx and watch o_cfg_vld, popping and comparing as the DUT produces them.
module tb_rf_resp_sim;

  localparam int CLK_FREQ = 1000;
  localparam int BAUD     = 100;
  localparam int TURN_CYC = 20;
  localparam int IDLE_TO  = 400;
  localparam int BIT_CYC  = CLK_FREQ / BAUD;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_rx  = 1'b1;
  logic        o_tx, o_tx_ctrl, o_cfg_vld;
  logic [15:0] o_rf_freq;
  logic [7:0]  o_up_gain, o_down_gain;
  logic [31:0] o_frm_cnt, o_err_cnt;

  int          tests = 0;
  int          fails = 0;
  bit          mon_en = 1'b1;
  logic [7:0]  exp_tx [$];
  logic [31:0] exp_cfg [$];

  rf_resp_sim #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .TURN_CYC(TURN_CYC), .IDLE_TO(IDLE_TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_rx(i_rx), .o_tx(o_tx), .o_tx_ctrl(o_tx_ctrl),
    .o_rf_freq(o_rf_freq), .o_up_gain(o_up_gain), .o_down_gain(o_down_gain),
    .o_cfg_vld(o_cfg_vld), .o_frm_cnt(o_frm_cnt), .o_err_cnt(o_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One 8N1 character, driven on negedges; stop_ok=0 forces a low stop bit.
  task automatic sendByte(input logic [7:0] b, input bit stop_ok);
    @(negedge clk);
    i_rx = 1'b0;
    repeat (BIT_CYC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      repeat (BIT_CYC) @(negedge clk);
    end
    i_rx = stop_ok;
    repeat (BIT_CYC) @(negedge clk);
    i_rx = 1'b1;
  endtask

  task automatic applyStimulus(input logic [63:0] frame);
    for (int i = 0; i < 8; i++) sendByte(frame[63 - 8*i -: 8], 1'b1);
  endtask

  task automatic expectAnswer(input logic [63:0] frame);
    for (int i = 0; i < 8; i++) exp_tx.push_back(frame[63 - 8*i -: 8]);
  endtask

  task automatic waitIdle(input string name, input int budget);
    int n = 0;
    while ((exp_tx.size() != 0 || o_tx_ctrl) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, " answer completed"}, 32'(n < budget), 32'd1);
  endtask

  task automatic waitDeHigh(input string name);
    int n = 0;
    while (!o_tx_ctrl && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, " driver enabled"}, 32'(o_tx_ctrl), 32'd1);
  endtask

  task automatic checkCounters(input string name, input logic [31:0] frm, input logic [31:0] err);
    checkOutput({name, " frm_cnt"}, o_frm_cnt, frm);
    checkOutput({name, " err_cnt"}, o_err_cnt, err);
  endtask

  task automatic checkConfig(input string name, input logic [31:0] cfg);
    checkOutput({name, " config"}, {o_rf_freq, o_up_gain, o_down_gain}, cfg);
  endtask

  // Answer-line monitor: UART receiver sampling mid-bit on negedges.
  always begin : tx_monitor
    logic [7:0] b;
    logic       stop;
    @(negedge clk);
    if (o_tx === 1'b0) begin
      repeat (BIT_CYC/2 - 1) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (BIT_CYC) @(negedge clk);
        b[i] = o_tx;
      end
      repeat (BIT_CYC) @(negedge clk);
      stop = o_tx;
      if (mon_en) begin
        if (exp_tx.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected answer byte: got 0x%0h, expected none", b);
        end else begin
          checkOutput("answer byte", {23'd0, stop, b}, {23'd0, 1'b1, exp_tx.pop_front()});
        end
      end
    end
  end

  // Config monitor: each pulse must carry the queued config, last one cycle,
  // and be followed by the driver enable one cycle plus TURN_CYC later.
  always begin : cfg_monitor
    int n;
    @(negedge clk);
    if (rst_n && o_cfg_vld === 1'b1) begin
      if (exp_cfg.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected cfg_vld: got 0x%0h, expected no pulse", o_rf_freq);
      end else begin
        checkOutput("cfg_vld config", {o_rf_freq, o_up_gain, o_down_gain}, exp_cfg.pop_front());
      end
      @(negedge clk);
      checkOutput("cfg_vld width", 32'(o_cfg_vld), 32'd0);
      n = 1;
      while (!o_tx_ctrl && n < 100) begin
        @(negedge clk);
        n++;
      end
      checkOutput("turnaround cycles", 32'(n), 32'(TURN_CYC + 1));
    end
  end

  initial begin : watchdog
    #3000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    bit ctrl_seen;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset o_tx", 32'(o_tx), 32'd1);
    checkOutput("reset o_tx_ctrl", 32'(o_tx_ctrl), 32'd0);
    checkOutput("reset o_cfg_vld", 32'(o_cfg_vld), 32'd0);
    checkConfig("reset", 32'h0);
    checkCounters("reset", 32'd0, 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Set: checksum 01^12^34^0A^0B = 26; answer checksum 81^12^34^0A^0B = A6
    exp_cfg.push_back({16'h1234, 8'h0A, 8'h0B});
    expectAnswer(64'h55AA8112340A0BA6);
    applyStimulus(64'hAA550112340A0B26);
    waitIdle("set", 3000);
    checkCounters("set", 32'd1, 32'd0);
    checkConfig("set", {16'h1234, 8'h0A, 8'h0B});

    // Ask: answer checksum 82^12^34^0A^0B = A5
    expectAnswer(64'h55AA8212340A0BA5);
    applyStimulus(64'hAA55020000000002);
    waitIdle("ask", 3000);
    checkCounters("ask", 32'd2, 32'd0);
    checkConfig("ask", {16'h1234, 8'h0A, 8'h0B});

    // Bad checksum: silent, error counted
    applyStimulus(64'hAA550112340A0B15);
    ctrl_seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (o_tx_ctrl) ctrl_seen = 1'b1;
    end
    checkOutput("bad chk driver idle", 32'(ctrl_seen), 32'd0);
    checkCounters("bad chk", 32'd2, 32'd1);
    checkConfig("bad chk", {16'h1234, 8'h0A, 8'h0B});

    // Framing error on a lone byte
    sendByte(8'h00, 1'b0);
    repeat (20) @(negedge clk);
    checkCounters("framing", 32'd2, 32'd2);

    // Partial frame then silence: one timeout error
    sendByte(8'hAA, 1'b1);
    sendByte(8'h55, 1'b1);
    sendByte(8'h01, 1'b1);
    repeat (500) @(negedge clk);
    checkCounters("timeout", 32'd2, 32'd3);

    // Good frame after timeout: 01^56^78^9C^3E = 8D; answer 81^... = 0D
    exp_cfg.push_back({16'h5678, 8'h9C, 8'h3E});
    expectAnswer(64'h55AA8156789C3E0D);
    applyStimulus(64'hAA550156789C3E8D);
    waitIdle("post timeout", 3000);
    checkCounters("post timeout", 32'd3, 32'd3);
    checkConfig("post timeout", {16'h5678, 8'h9C, 8'h3E});

    // Busy: ask answer 82^56^78^9C^3E = 0E; a set frame sent during it is dropped
    expectAnswer(64'h55AA8256789C3E0E);
    applyStimulus(64'hAA55020000000002);
    waitDeHigh("busy");
    applyStimulus(64'hAA55011122334445);
    waitIdle("busy", 3000);
    repeat (50) @(negedge clk);
    checkCounters("busy", 32'd4, 32'd3);
    checkConfig("busy", {16'h5678, 8'h9C, 8'h3E});

    // Reset in the middle of an answer
    mon_en = 1'b0;
    applyStimulus(64'hAA55020000000002);
    waitDeHigh("reset mid-send");
    repeat (300) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("reset mid-send o_tx_ctrl", 32'(o_tx_ctrl), 32'd0);
    checkOutput("reset mid-send o_tx", 32'(o_tx), 32'd1);
    checkCounters("reset mid-send", 32'd0, 32'd0);
    checkConfig("reset mid-send", 32'h0);
    exp_tx.delete();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    ctrl_seen = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (o_tx_ctrl) ctrl_seen = 1'b1;
    end
    checkOutput("no partial answer after reset", 32'(ctrl_seen), 32'd0);
    mon_en = 1'b1;

    // Block is fully usable again after reset
    exp_cfg.push_back({16'h1234, 8'h0A, 8'h0B});
    expectAnswer(64'h55AA8112340A0BA6);
    applyStimulus(64'hAA550112340A0B26);
    waitIdle("after reset", 3000);
    checkCounters("after reset", 32'd1, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
